li_rr_merge: RTL

LI_RR_MERGE -- requirements
Module: li_rr_merge

---
 rtl/llpm_pipeline_pkg.sv | 19 +
 rtl/li_rr_pick.sv | 34 +++
 rtl/li_rr_merge.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/llpm_pipeline_pkg.sv
// Shared constants and helpers for the latency-insensitive pipeline blocks.
package llpm_pipeline_pkg;

    // Largest channel count any merge/arbiter in the pipeline library supports.
    localparam int MAX_INPUTS = 16;

    // Bits needed to encode an index in 0..n-1, never less than one bit.
    function automatic int clog2_w(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/li_rr_pick.sv
// Rotate-priority picker: first asserted bit of valid at or above ptr,
// wrapping from the top channel back to channel 0.
module li_rr_pick
    import llpm_pipeline_pkg::*;
#(
    parameter int NumInputs = 4,
    localparam int IdxW = clog2_w(NumInputs)
) (
    input  logic [NumInputs-1:0] valid,
    input  logic [IdxW-1:0]      ptr,
    output logic [IdxW-1:0]      winner,
    output logic                 any
);

    int idx;

    // Walk channels starting at ptr and keep the first valid one found.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 0; k < NumInputs; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NumInputs) begin
                idx = idx - NumInputs;
            end
            if (!any && valid[idx[IdxW-1:0]]) begin
                any    = 1'b1;
                winner = idx[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/li_rr_merge.sv
// Round-robin merge of NumInputs latency-insensitive channels into one,
// buffered by a 2-entry output FIFO whose head drives q directly.
// Optional feature: define LLPM_MERGE_IDX_EN to add a q_idx output that
// reports the source channel of the head token.
module li_rr_merge
    import llpm_pipeline_pkg::*;
#(
    parameter string Name      = "",
    parameter int    Width     = 8,
    parameter int    NumInputs = 4,
    localparam int   IdxW      = clog2_w(NumInputs)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NumInputs*Width-1:0] d,
    input  logic [NumInputs-1:0]       d_valid,
    output logic [NumInputs-1:0]       d_bp,
    output logic [Width-1:0]           q,
    output logic                       q_valid,
    input  logic                       q_bp
`ifdef LLPM_MERGE_IDX_EN
    ,
    output logic [IdxW-1:0]            q_idx
`endif
);

    if (NumInputs < 2 || NumInputs > MAX_INPUTS) begin : g_bad_inputs
        $error("li_rr_merge %s: NumInputs=%0d outside 2..%0d", Name, NumInputs, MAX_INPUTS);
    end

    logic [1:0]       count_q, count_d;
    logic [IdxW-1:0]  ptr_q, ptr_d;
    logic [Width-1:0] head_data_q, head_data_d;
    logic [Width-1:0] tail_data_q, tail_data_d;
`ifdef LLPM_MERGE_IDX_EN
    logic [IdxW-1:0]  head_idx_q, head_idx_d;
    logic [IdxW-1:0]  tail_idx_q, tail_idx_d;
`endif

    logic [IdxW-1:0]  winner;
    logic             any;
    logic             pop;
    logic             push;
    logic [Width-1:0] new_data;

    li_rr_pick #(
        .NumInputs (NumInputs)
    ) u_pick (
        .valid  (d_valid),
        .ptr    (ptr_q),
        .winner (winner),
        .any    (any)
    );

    assign q_valid = (count_q != 2'd0);
    assign q       = head_data_q;
`ifdef LLPM_MERGE_IDX_EN
    assign q_idx   = head_idx_q;
`endif

    // Grant the picked channel only when a FIFO slot is free or the head leaves this cycle.
    always_comb begin
        pop      = q_valid && !q_bp;
        push     = !reset && any && ((count_q != 2'd2) || pop);
        new_data = d[int'(winner)*Width +: Width];
        d_bp     = '1;
        if (push) begin
            d_bp[winner] = 1'b0;
        end
    end

    // FIFO and round-robin pointer next state; a push/pop pair keeps the count and order.
    always_comb begin
        count_d     = count_q;
        ptr_d       = ptr_q;
        head_data_d = head_data_q;
        tail_data_d = tail_data_q;
`ifdef LLPM_MERGE_IDX_EN
        head_idx_d  = head_idx_q;
        tail_idx_d  = tail_idx_q;
`endif
        if (push) begin
            ptr_d = (winner == IdxW'(NumInputs - 1)) ? '0 : winner + IdxW'(1);
        end
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_data_d = new_data;
`ifdef LLPM_MERGE_IDX_EN
                    head_idx_d  = winner;
`endif
                end else begin
                    tail_data_d = new_data;
`ifdef LLPM_MERGE_IDX_EN
                    tail_idx_d  = winner;
`endif
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_data_d = tail_data_q;
`ifdef LLPM_MERGE_IDX_EN
                head_idx_d  = tail_idx_q;
`endif
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_data_d = new_data;
`ifdef LLPM_MERGE_IDX_EN
                    head_idx_d  = winner;
`endif
                end else begin
                    head_data_d = tail_data_q;
                    tail_data_d = new_data;
`ifdef LLPM_MERGE_IDX_EN
                    head_idx_d  = tail_idx_q;
                    tail_idx_d  = winner;
`endif
                end
            end
            default: begin
            end
        endcase
    end

    // State registers; reset drops any buffered tokens and rewinds the pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= 2'd0;
            ptr_q       <= '0;
            head_data_q <= '0;
            tail_data_q <= '0;
`ifdef LLPM_MERGE_IDX_EN
            head_idx_q  <= '0;
            tail_idx_q  <= '0;
`endif
        end else begin
            count_q     <= count_d;
            ptr_q       <= ptr_d;
            head_data_q <= head_data_d;
            tail_data_q <= tail_data_d;
`ifdef LLPM_MERGE_IDX_EN
            head_idx_q  <= head_idx_d;
            tail_idx_q  <= tail_idx_d;
`endif
        end
    end

endmodule
